// File: rtl/rr_stream_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rr_stream_arbiter_pkg
// Shared definitions for the round-robin stream arbiter and its pick logic.
//   - calc_src_w : width of a source-index field (clog2, never below 1)
//   - lock_state_t : packet-lock FSM states (used when ARB_PKT_LOCK_EN is set)
//   - PTR_RST / SRC_ID_RST : reset values of the priority pointer and the
//     output source id
// No ports (package).
// ----------------------------------------------------------------------------
package rr_stream_arbiter_pkg;

  typedef enum logic [0:0] {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_t;

  localparam int PTR_RST    = 32'sd0;
  localparam int SRC_ID_RST = 32'sd0;

  // A 1-source or 2-source arbiter still needs a 1-bit index field.
  function automatic int calc_src_w(input int n);
    int w;
    if (n < 32'sd2) begin
      w = 32'sd1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_stream_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Purely combinational rotate-priority encoder. Searches req starting at ptr,
// ascending, wrapping NUM_SRC-1 -> 0, and grants the first set bit.
// Ports:
//   req  [NUM_SRC-1:0] in  : request vector
//   ptr  [SRC_W-1:0]   in  : highest-priority index (must be < NUM_SRC)
//   gnt  [NUM_SRC-1:0] out : one-hot grant (zero when no request)
//   idx  [SRC_W-1:0]   out : encoded grant index (zero when no request)
//   any                out : at least one request present
// ----------------------------------------------------------------------------
module rr_pick
  import rr_stream_arbiter_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int SRC_W   = calc_src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);

  logic found_s;

  // Two-pass search: first the indices at/above ptr, then the wrapped ones
  // below ptr. Constant loop indices keep this free of variable bit-selects,
  // and it works for non-power-of-two NUM_SRC.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found_s && req[i] && (SRC_W'(i) >= ptr)) begin
        found_s = 1'b1;
        gnt[i]  = 1'b1;
        idx     = SRC_W'(i);
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found_s && req[i] && (SRC_W'(i) < ptr)) begin
        found_s = 1'b1;
        gnt[i]  = 1'b1;
        idx     = SRC_W'(i);
      end else begin
        found_s = found_s;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// ----------------------------------------------------------------------------
// rr_stream_arbiter
// N-to-1 round-robin arbiter merging NUM_SRC valid/ready streams into one
// registered valid/ready stream (1-cycle latency, one beat per cycle).
// Optional packet lock: define ARB_PKT_LOCK_EN to keep the grant on one
// source until it sends a beat with src_last set.
// Ports:
//   clk                         in  : clock, rising edge
//   rst                         in  : synchronous reset, active-low
//   src_valid [NUM_SRC-1:0]     in  : per-source beat valid
//   src_data  [NUM_SRC*DATA_W-1:0] in : source i at [i*DATA_W +: DATA_W]
//   src_last  [NUM_SRC-1:0]     in  : end-of-packet (lock build only)
//   src_ready [NUM_SRC-1:0]     out : per-source accept, one-hot or zero
//   out_valid                   out : registered beat valid
//   out_data  [DATA_W-1:0]      out : registered payload
//   out_src_id [SRC_W-1:0]      out : source index of the current beat
//   out_ready                   in  : downstream accept
// ----------------------------------------------------------------------------
module rr_stream_arbiter
  import rr_stream_arbiter_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  parameter  int DATA_W  = 8,
  localparam int SRC_W   = calc_src_w(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src_id,
  input  logic                      out_ready
);

  logic [SRC_W-1:0]   ptr_r;
  logic               out_valid_r;
  logic [DATA_W-1:0]  out_data_r;
  logic [SRC_W-1:0]   out_src_id_r;

  logic               load_en_s;
  logic               xfer_s;
  logic               ptr_upd_s;
  logic [NUM_SRC-1:0] req_s;
  logic [NUM_SRC-1:0] gnt_s;
  logic [SRC_W-1:0]   gnt_idx_s;
  logic               any_s;
  logic [NUM_SRC-1:0] src_ready_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic [SRC_W-1:0]   ptr_next_s;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req (req_s),
    .ptr (ptr_r),
    .gnt (gnt_s),
    .idx (gnt_idx_s),
    .any (any_s)
  );

  // Handshake: accept a beat when the output register is free or draining.
  // Gating with rst keeps src_ready low for the whole reset cycle.
  always_comb begin
    load_en_s = !out_valid_r || out_ready;
    xfer_s    = rst && load_en_s && any_s;
    if (xfer_s) begin
      src_ready_s = gnt_s;
    end else begin
      src_ready_s = '0;
    end
  end

  // Payload mux driven by the one-hot grant, plus the wrapped next pointer.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_s[i]) begin
        sel_data_s = sel_data_s | src_data[i*DATA_W +: DATA_W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
    if (gnt_idx_s == SRC_W'(NUM_SRC - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = gnt_idx_s + SRC_W'(1);
    end
  end

`ifdef ARB_PKT_LOCK_EN
  lock_state_t        lock_state_r;
  lock_state_t        lock_state_next_s;
  logic [SRC_W-1:0]   lock_src_r;
  logic [NUM_SRC-1:0] lock_mask_s;
  logic               last_sel_s;

  assign last_sel_s = |(gnt_s & src_last);

  // Lock state register; captures the packet owner on an opening beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_state_r <= LK_IDLE;
      lock_src_r   <= SRC_W'(SRC_ID_RST);
    end else begin
      lock_state_r <= lock_state_next_s;
      if (xfer_s && (lock_state_r == LK_IDLE)) begin
        lock_src_r <= gnt_idx_s;
      end else begin
        lock_src_r <= lock_src_r;
      end
    end
  end

  // Lock next-state: open on a non-last beat, close on a last beat.
  always_comb begin
    lock_state_next_s = lock_state_r;
    case (lock_state_r)
      LK_IDLE: begin
        if (xfer_s && !last_sel_s) begin
          lock_state_next_s = LK_LOCKED;
        end else begin
          lock_state_next_s = LK_IDLE;
        end
      end
      LK_LOCKED: begin
        if (xfer_s && last_sel_s) begin
          lock_state_next_s = LK_IDLE;
        end else begin
          lock_state_next_s = LK_LOCKED;
        end
      end
      default: lock_state_next_s = LK_IDLE;
    endcase
  end

  // Lock outputs: request mask and pointer-update enable. The pointer is
  // frozen inside a packet and advances past the owner on its last beat.
  always_comb begin
    lock_mask_s = '1;
    ptr_upd_s   = 1'b0;
    case (lock_state_r)
      LK_IDLE: begin
        lock_mask_s = '1;
        ptr_upd_s   = xfer_s;
      end
      LK_LOCKED: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          lock_mask_s[i] = (lock_src_r == SRC_W'(i));
        end
        ptr_upd_s = xfer_s && last_sel_s;
      end
      default: begin
        lock_mask_s = '1;
        ptr_upd_s   = 1'b0;
      end
    endcase
    req_s = src_valid & lock_mask_s;
  end
`else
  logic unused_last_s;

  assign unused_last_s = ^src_last;

  // Without packet lock every beat is arbitrated independently.
  always_comb begin
    req_s     = src_valid;
    ptr_upd_s = xfer_s;
  end
`endif

  // Priority pointer: moves only on a transfer, to one past the winner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_r <= SRC_W'(PTR_RST);
    end else if (ptr_upd_s) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Output register: load on transfer, drop valid when free and idle,
  // hold everything under backpressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_src_id_r <= SRC_W'(SRC_ID_RST);
    end else if (xfer_s) begin
      out_valid_r  <= 1'b1;
      out_data_r   <= sel_data_s;
      out_src_id_r <= gnt_idx_s;
    end else if (load_en_s) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= out_data_r;
      out_src_id_r <= out_src_id_r;
    end else begin
      out_valid_r  <= out_valid_r;
      out_data_r   <= out_data_r;
      out_src_id_r <= out_src_id_r;
    end
  end

  assign src_ready  = src_ready_s;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_src_id = out_src_id_r;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_stream_arbiter
// Directed self-checking bench for rr_stream_arbiter (NUM_SRC=4, DATA_W=8).
// Inputs change 1 time unit after the rising edge; src_ready is sampled
// before the next edge and registered outputs 1 unit after it.
// Define ARB_PKT_LOCK_EN for both bench and RTL to exercise packet lock.
// ----------------------------------------------------------------------------
module tb_rr_stream_arbiter;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 8;
  localparam int SRC_W   = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_last;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [SRC_W-1:0]          out_src_id;
  logic                      out_ready;

  int errors = 0;
  int checks = 0;

  localparam logic [NUM_SRC*DATA_W-1:0] DATA_A = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  always #5 clk = ~clk;

  rr_stream_arbiter #(
    .NUM_SRC (NUM_SRC),
    .DATA_W  (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_last   (src_last),
    .src_ready  (src_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src_id (out_src_id),
    .out_ready  (out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    src_valid = 4'b0000;
    src_last  = 4'b0000;
    src_data  = DATA_A;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rst = 1'b1;
      #1;
      checks++;
      if (src_ready !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ready cyc%0d: got %b want 0000", c, src_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src_id !== 2'd0) begin
        errors++;
        $display("FAIL reset_out cyc%0d: got v=%b d=%h id=%0d want v=0 d=00 id=0",
                 c, out_valid, out_data, out_src_id);
      end
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_ready;
    logic [3:0] one_v;
    int         exp_id;
    one_v     = 4'b0001;
    src_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_id    = k % 4;
      exp_ready = one_v << exp_id;
      #1;
      checks++;
      if (src_ready !== exp_ready) begin
        errors++;
        $display("FAIL contention_ready beat%0d: got %b want %b", k, src_ready, exp_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src_id !== SRC_W'(exp_id) ||
          out_data !== (8'hA0 + 8'(exp_id))) begin
        errors++;
        $display("FAIL contention_out beat%0d: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                 k, out_valid, out_src_id, out_data, exp_id, 8'hA0 + 8'(exp_id));
      end
    end
  endtask

  task automatic test_backpressure();
    // ptr is 1 here: load 0x55 from source 1, then stall.
    src_data  = {8'hA3, 8'hA2, 8'h55, 8'hA0};
    src_valid = 4'b1111;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== 8'h55 || out_src_id !== 2'd1) begin
      errors++;
      $display("FAIL bp_load: got d=%h id=%0d want d=55 id=1", out_data, out_src_id);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (src_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready cyc%0d: got %b want 0000", c, src_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h55 || out_src_id !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: got v=%b d=%h id=%0d want v=1 d=55 id=1",
                 c, out_valid, out_data, out_src_id);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (src_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 0100", src_ready);
    end
    tick();
    checks++;
    if (out_src_id !== 2'd2 || out_data !== 8'hA2) begin
      errors++;
      $display("FAIL bp_release_out: got id=%0d d=%h want id=2 d=a2", out_src_id, out_data);
    end
    src_data = DATA_A;
  endtask

  task automatic test_sparse_wrap();
    // ptr is 3: 0101 must wrap to source 0.
    src_valid = 4'b0101;
    #1;
    checks++;
    if (src_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_ready: got %b want 0001", src_ready);
    end
    tick();
    checks++;
    if (out_src_id !== 2'd0 || out_data !== 8'hA0) begin
      errors++;
      $display("FAIL wrap_out: got id=%0d d=%h want id=0 d=a0", out_src_id, out_data);
    end
    src_valid = 4'b0100;
    #1;
    checks++;
    if (src_ready !== 4'b0100) begin
      errors++;
      $display("FAIL sparse_ready: got %b want 0100", src_ready);
    end
    tick();
    checks++;
    if (out_src_id !== 2'd2 || out_data !== 8'hA2) begin
      errors++;
      $display("FAIL sparse_out: got id=%0d d=%h want id=2 d=a2", out_src_id, out_data);
    end
    // Idle with out_ready high: valid drops, data and id hold.
    src_valid = 4'b0000;
    #1;
    checks++;
    if (src_ready !== 4'b0000) begin
      errors++;
      $display("FAIL idle_ready: got %b want 0000", src_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_src_id !== 2'd2 || out_data !== 8'hA2) begin
      errors++;
      $display("FAIL idle_out: got v=%b id=%0d d=%h want v=0 id=2 d=a2",
               out_valid, out_src_id, out_data);
    end
  endtask

  task automatic test_reset_mid();
    // ptr is 3: single request from source 0, ptr becomes 1.
    src_valid = 4'b0001;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    src_valid = 4'b1111;
    rst       = 1'b0;
    #1;
    checks++;
    if (src_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_ready: got %b want 0000", src_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src_id !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_out: got v=%b d=%h id=%0d want v=0 d=00 id=0",
               out_valid, out_data, out_src_id);
    end
    rst       = 1'b1;
    out_ready = 1'b1;
    // ptr cleared to 0 (it was 1): full contention grants source 0.
    #1;
    checks++;
    if (src_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_ptr: got %b want 0001", src_ready);
    end
    tick();
    src_valid = 4'b1000;
    #1;
    checks++;
    if (src_ready !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_src3_ready: got %b want 1000", src_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src_id !== 2'd3 || out_data !== 8'hA3) begin
      errors++;
      $display("FAIL rstmid_src3_out: got v=%b id=%0d d=%h want v=1 id=3 d=a3",
               out_valid, out_src_id, out_data);
    end
  endtask

  task automatic test_packet();
    // ptr is 0; source 1 sends last=0,0,1 while source 2 requests throughout.
    logic [3:0] exp_ready [4];
    int         exp_id    [4];
    logic [3:0] last_seq  [4];
    last_seq = '{4'b0000, 4'b0000, 4'b0010, 4'b0000};
`ifdef ARB_PKT_LOCK_EN
    exp_ready = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
    exp_id    = '{1, 1, 1, 2};
`else
    exp_ready = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
    exp_id    = '{1, 2, 1, 2};
`endif
    src_valid = 4'b0110;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      src_last = last_seq[k];
      #1;
      checks++;
      if (src_ready !== exp_ready[k]) begin
        errors++;
        $display("FAIL packet_ready beat%0d: got %b want %b", k, src_ready, exp_ready[k]);
      end
      tick();
      checks++;
      if (out_src_id !== SRC_W'(exp_id[k]) || out_data !== (8'hA0 + 8'(exp_id[k]))) begin
        errors++;
        $display("FAIL packet_out beat%0d: got id=%0d d=%h want id=%0d",
                 k, out_src_id, out_data, exp_id[k]);
      end
    end
    src_valid = 4'b0000;
    src_last  = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_backpressure();
    test_sparse_wrap();
    test_reset_mid();
    test_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- N-to-1 round-robin arbiter merging NUM_SRC valid/ready source streams into one valid/ready stream.
- Sits directly upstream of the valid/ready pipeline (skid) stage.
- That stage registers ready back toward this block, which cuts the combinational out_ready -> src_ready path.
- Output is registered: 1-cycle latency, full throughput of one beat per cycle.

Parameters:
- NUM_SRC, 4, number of requesting sources; 2..32, non-power-of-two allowed.
- DATA_W, 8, payload width per source.
- SRC_W, $clog2(NUM_SRC), width of source-id field (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-low.
- src_valid  input  NUM_SRC  per-source beat valid.
- src_data  input  NUM_SRC*DATA_W  packed payloads; source i at bits [i*DATA_W +: DATA_W].
- src_last  input  NUM_SRC  per-source end-of-packet flag; used only with ARB_PKT_LOCK_EN.
- src_ready  output  NUM_SRC  per-source accept; at most one bit high (one-hot or zero).
- out_valid  output  1  registered output beat valid.
- out_data  output  DATA_W  registered payload.
- out_src_id  output  SRC_W  index of the source that produced the current beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst==0 at a clk edge):
  - out_valid=0, out_data=0, out_src_id=0.
  - Priority pointer ptr=0, so source 0 has highest priority.
  - Lock state = IDLE.
  - A beat in flight is dropped.
  - src_ready=0 throughout the reset cycle.
- load_en = !out_valid || out_ready. This is combinational.
- Grant selection (combinational):
  - Search src_valid starting at ptr, ascending, wrapping NUM_SRC-1 -> 0.
  - The first valid source g is granted.
- src_ready[g] = load_en && any src_valid. All other bits are 0.
- Transfer on source g = src_valid[g] && src_ready[g]. On the next edge:
  - out_valid=1, out_data=src_data[g], out_src_id=g.
  - ptr = (g+1) mod NUM_SRC.
- Output register behaviour:
  - If load_en and no source is valid: out_valid=0 next cycle; out_data and out_src_id hold; ptr holds.
  - If out_valid && !out_ready: out_data and out_src_id stay stable and all src_ready=0 (no overwrite).
- Back-to-back: with out_ready held high, one beat per cycle. A single persistent requester is granted every cycle.
- All sources requesting continuously: grant order is 0,1,2,...,NUM_SRC-1,0,...
- A source may drop src_valid before being granted. No state is kept for it, and no fairness credit is retained.
- ptr changes only on a transfer.

Optional Feature:
- Macro: ARB_PKT_LOCK_EN.
- Defined: two-state lock FSM.
  - IDLE: arbitration as above. A transfer with src_last[g]==0 moves to LOCKED and holds g as the locked source.
  - LOCKED: only the locked source can be granted; others see src_ready=0 even when out_ready is high. A transfer with src_last==1 returns to IDLE and sets ptr=(g+1) mod NUM_SRC.
  - ptr does not move while LOCKED.
  - Reset forces IDLE.
- Not defined: src_last is ignored, no FSM exists, and every beat is arbitrated independently.

Decomposition:
- Shared package holds:
  - SRC_W calculation function (clog2 with a minimum of 1).
  - Lock-state typedef {LK_IDLE, LK_LOCKED}.
  - Reset constants for ptr and out_src_id.
- One natural sub-module: rr_pick.
  - Purely combinational rotate-priority encoder.
  - Inputs: request vector and ptr. Outputs: one-hot grant, encoded index, any-valid.
  - Reusable by the 32-way arbiter.
- Top level holds ptr, the output register and the optional lock FSM.

Test Plan:
1. Reset then idle: rst=0 for 2 cycles, then 1 with src_valid=0000. Expect out_valid=0, out_data=0, out_src_id=0, src_ready=0000 throughout.
2. Full contention: NUM_SRC=4, src_valid=1111 with data 0xA0..0xA3, out_ready=1. Expect out_src_id sequence 0,1,2,3,0 on consecutive cycles with out_data 0xA0,0xA1,0xA2,0xA3,0xA0, and exactly one src_ready high per cycle.
3. Backpressure: out_valid=1 with out_data=0x55, out_ready=0 for 3 cycles, src_valid=1111. Expect out_data held at 0x55, src_ready=0000 and ptr unchanged. When out_ready rises, the next source is granted in the same cycle.
4. Sparse and wrap: ptr=3 and src_valid=0101. Expect grant of source 0 and ptr=1 afterwards. Next cycle with src_valid=0100, expect grant of source 2 and ptr=3.
5. Reset mid-operation: assert rst=0 while out_valid=1 and out_ready=0. Next cycle expect out_valid=0 and ptr=0. After release with src_valid=1000, expect grant of source 3.
6. ARB_PKT_LOCK_EN: source 1 sends 3 beats with src_last=0,0,1 while source 2 requests continuously. Expect out_src_id=1,1,1 then 2, and src_ready[2]=0 during the lock.
